// File: rtl/core_pkg.sv
// Shared core definitions: datapath width, the fetch buffer entry and the fetch state encoding.
package core_pkg;

    localparam int Xlen = 32;
    localparam logic [31:0] NopInst = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]     inst;
        logic [Xlen-1:0] pc;
        logic            misaligned;
    } fetch_entry_t;

    typedef enum logic {
        FETCH_RUN  = 1'b0,
        FETCH_HALT = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/fifo_sync.sv
// Registered synchronous FIFO with synchronous flush and an occupancy count.
// A pushed word is visible on pop_data_o from the following cycle.
module fifo_sync #(
    parameter int Width = 8,
    parameter int Depth = 2,
    localparam int CntW = $clog2(Depth + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             pop_i,
    output logic [Width-1:0] pop_data_o,
    output logic [CntW-1:0]  count_o
);

    localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
        if (ptr == PtrW'(Depth - 1)) begin
            return '0;
        end
        return ptr + PtrW'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop_i && (count_q != '0);
        // A full FIFO may still accept a push when the head leaves in the same cycle.
        do_push  = push_i && ((count_q != CntW'(Depth)) || do_pop);

        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data_i;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: in-order imem requests, response buffering and redirect handling.
// Define FETCH_MISALIGN_CHK_EN to halt on misaligned redirect targets and flag them to decode.
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [Xlen-1:0] ResetPc        = '0,
    parameter int              BufDepth       = 2,
    parameter int              MaxOutstanding = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [Xlen-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    input  logic            imem_req_ready_i,
    output logic [Xlen-1:0] imem_req_addr_o,
    input  logic            imem_resp_valid_i,
    input  logic [31:0]     imem_resp_data_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [Xlen-1:0] inst_pc_o
`ifdef FETCH_MISALIGN_CHK_EN
    ,
    output logic            inst_misaligned_o
`endif
);

    localparam int OutW   = $clog2(MaxOutstanding + 1);
    localparam int CntW   = $clog2(BufDepth + 1);
    localparam int EntryW = $bits(fetch_entry_t);

    logic [Xlen-1:0] fetch_pc_q, fetch_pc_d;
    logic [Xlen-1:0] resp_pc_q, resp_pc_d;
    logic [OutW-1:0] outstanding_q, outstanding_d;
    logic [OutW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CntW-1:0] buf_count;
    fetch_entry_t    buf_head;
    fetch_entry_t    push_entry;
    logic            buf_push, buf_pop;
    logic            req_fire, resp_discard;
    logic            halted;
    logic [Xlen-1:0] redirect_target;
    int              credit_used;

`ifdef FETCH_MISALIGN_CHK_EN
    fetch_state_e state_q, state_d;
    logic         halt_valid_q, halt_valid_d;
    logic         redirect_misaligned;

    assign redirect_target     = redirect_pc_i;
    assign redirect_misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
    assign halted              = (state_q == FETCH_HALT);

    // HALT presents a single synthetic nop entry; only a redirect leaves it.
    always_comb begin
        state_d      = state_q;
        halt_valid_d = halt_valid_q;
        if (halted && inst_ready_i) begin
            halt_valid_d = 1'b0;
        end
        if (redirect_i) begin
            state_d      = redirect_misaligned ? FETCH_HALT : FETCH_RUN;
            halt_valid_d = redirect_misaligned;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= FETCH_RUN;
            halt_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            halt_valid_q <= halt_valid_d;
        end
    end

    assign inst_valid_o      = halted ? halt_valid_q : (buf_count != '0);
    assign inst_o            = halted ? NopInst : buf_head.inst;
    assign inst_pc_o         = halted ? fetch_pc_q : buf_head.pc;
    assign inst_misaligned_o = halted ? 1'b1 : buf_head.misaligned;
`else
    logic unused_bits;

    assign redirect_target = {redirect_pc_i[Xlen-1:2], 2'b00};
    assign halted          = 1'b0;
    assign unused_bits     = ^{redirect_pc_i[1:0], buf_head.misaligned};
    assign inst_valid_o    = (buf_count != '0);
    assign inst_o          = buf_head.inst;
    assign inst_pc_o       = buf_head.pc;
`endif

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        buf_pop       = inst_valid_o && inst_ready_i && !halted;

        // Buffer slots freed by this cycle's pop count as credit, giving one fetch per cycle.
        credit_used   = int'(outstanding_q) - int'(drop_cnt_q) + int'(buf_count)
                        - (buf_pop ? 1 : 0);
        imem_req_valid_o = !rst_i && !redirect_i && !halted
                           && (int'(outstanding_q) < MaxOutstanding)
                           && (credit_used < BufDepth);
        req_fire      = imem_req_valid_o && imem_req_ready_i;

        resp_discard  = redirect_i || halted || (drop_cnt_q != '0);
        buf_push      = imem_resp_valid_i && !resp_discard;

        push_entry.inst       = imem_resp_data_i;
        push_entry.pc         = resp_pc_q;
        push_entry.misaligned = 1'b0;

        outstanding_d = outstanding_q + OutW'(req_fire) - OutW'(imem_resp_valid_i);

        if (req_fire) begin
            fetch_pc_d = fetch_pc_q + Xlen'(4);
        end
        if (buf_push) begin
            resp_pc_d = resp_pc_q + Xlen'(4);
        end
        if (imem_resp_valid_i && (drop_cnt_q != '0)) begin
            drop_cnt_d = drop_cnt_q - OutW'(1);
        end

        // Everything still in flight is wrong-path; a response landing now is dropped too.
        if (redirect_i) begin
            fetch_pc_d = redirect_target;
            resp_pc_d  = redirect_target;
            drop_cnt_d = outstanding_q - OutW'(imem_resp_valid_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fetch_pc_q    <= ResetPc;
            resp_pc_q     <= ResetPc;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    assign imem_req_addr_o = fetch_pc_q;

    fifo_sync #(
        .Width (EntryW),
        .Depth (BufDepth)
    ) u_inst_buf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .flush_i     (redirect_i),
        .push_i      (buf_push),
        .push_data_i (push_entry),
        .pop_i       (buf_pop),
        .pop_data_o  (buf_head),
        .count_o     (buf_count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: a directed vector table, hand-written redirect/wrap
// sequences and a randomized run checked against an in-order fetch stream model.
module tb_fetch_unit;
    import core_pkg::*;

    localparam int MaxOut = 2;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_valid_o;
    logic        imem_req_ready_i = 1'b0;
    logic [31:0] imem_req_addr_o;
    logic        imem_resp_valid_i = 1'b0;
    logic [31:0] imem_resp_data_i = '0;
    logic        inst_valid_o;
    logic        inst_ready_i = 1'b0;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
`ifdef FETCH_MISALIGN_CHK_EN
    logic        inst_misaligned_o;
`endif

    always #5 clk_i = ~clk_i;

    fetch_unit #(
        .ResetPc        (32'h0),
        .BufDepth       (2),
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .redirect_i        (redirect_i),
        .redirect_pc_i     (redirect_pc_i),
        .imem_req_valid_o  (imem_req_valid_o),
        .imem_req_ready_i  (imem_req_ready_i),
        .imem_req_addr_o   (imem_req_addr_o),
        .imem_resp_valid_i (imem_resp_valid_i),
        .imem_resp_data_i  (imem_resp_data_i),
        .inst_valid_o      (inst_valid_o),
        .inst_ready_i      (inst_ready_i),
        .inst_o            (inst_o),
        .inst_pc_o         (inst_pc_o)
`ifdef FETCH_MISALIGN_CHK_EN
        ,
        .inst_misaligned_o (inst_misaligned_o)
`endif
    );

    typedef struct {
        logic        redir;
        logic [31:0] tgt;
        logic        rdy;
        logic        req_rdy;
        logic        exp_req_valid;
        logic [31:0] exp_req_addr;
        logic        exp_inst_valid;
        logic [31:0] exp_inst_pc;
    } vec_t;

    vec_t        vecs[10];
    int          vec_cnt = 0;
    int          miscompare_cnt = 0;
    int          cycle = 0;
    int          mem_lat = 1;
    int          last_due = 0;
    int          deliveries = 0;
    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] exp_pc = '0;
    logic [31:0] exp_req_pc = '0;
    logic        s_req_valid, s_inst_valid, s_misaligned;
    logic [31:0] s_req_addr, s_inst, s_inst_pc;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F11;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miscompare_cnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)",
                     name, actual, expected, cycle);
        end
    endtask

    // One clock cycle: drive inputs, play the memory, sample outputs, update the stream model.
    task automatic applyStimulus(input logic redir, input logic [31:0] tgt,
                                 input logic rdy, input logic req_rdy);
        int due;
        @(posedge clk_i);
        #1;
        cycle++;
        redirect_i       = redir;
        redirect_pc_i    = tgt;
        inst_ready_i     = rdy;
        imem_req_ready_i = req_rdy;
        if (pend_addr.size() > 0 && pend_due[0] <= cycle) begin
            imem_resp_valid_i = 1'b1;
            imem_resp_data_i  = memWord(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_resp_valid_i = 1'b0;
            imem_resp_data_i  = $urandom();
        end
        @(negedge clk_i);
        s_req_valid  = imem_req_valid_o;
        s_req_addr   = imem_req_addr_o;
        s_inst_valid = inst_valid_o;
        s_inst       = inst_o;
        s_inst_pc    = inst_pc_o;
`ifdef FETCH_MISALIGN_CHK_EN
        s_misaligned = inst_misaligned_o;
`else
        s_misaligned = 1'b0;
`endif
        if (redir) begin
            checkOutput("no_req_on_redirect", 32'(s_req_valid), 32'd0);
        end
        if (s_req_valid && req_rdy) begin
            checkOutput("req_addr", s_req_addr, exp_req_pc);
            exp_req_pc = exp_req_pc + 32'd4;
            due = (cycle + mem_lat > last_due + 1) ? cycle + mem_lat : last_due + 1;
            last_due = due;
            pend_addr.push_back(s_req_addr);
            pend_due.push_back(due);
            checkOutput("inflight_limit", 32'(pend_addr.size() <= MaxOut), 32'd1);
        end
        if (s_inst_valid && rdy) begin
            checkOutput("inst_pc", s_inst_pc, exp_pc);
            checkOutput("inst_word", s_inst, memWord(exp_pc));
            exp_pc = exp_pc + 32'd4;
            deliveries++;
        end
        if (redir) begin
            exp_pc     = tgt;
            exp_req_pc = tgt;
        end
    endtask

    task automatic resetDut();
        @(posedge clk_i);
        #1;
        rst_i             = 1'b1;
        redirect_i        = 1'b0;
        redirect_pc_i     = '0;
        inst_ready_i      = 1'b0;
        imem_req_ready_i  = 1'b0;
        imem_resp_valid_i = 1'b0;
        imem_resp_data_i  = '0;
        #1;
        checkOutput("rst_req_valid", 32'(imem_req_valid_o), 32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid_o), 32'd0);
        checkOutput("rst_inst", inst_o, 32'd0);
        checkOutput("rst_inst_pc", inst_pc_o, 32'd0);
`ifdef FETCH_MISALIGN_CHK_EN
        checkOutput("rst_misaligned", 32'(inst_misaligned_o), 32'd0);
`endif
        pend_addr.delete();
        pend_due.delete();
        last_due   = 0;
        exp_pc     = '0;
        exp_req_pc = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, cycle %0d", cycle);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic        found;
        logic [31:0] tgt;
        int          d0;

        // redir, tgt, rdy, req_rdy, exp_req_valid, exp_req_addr, exp_inst_valid, exp_inst_pc
        vecs[0] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
        vecs[1] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
        vecs[2] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
        vecs[3] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h04};
        vecs[4] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
        vecs[5] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h00, 1'b1, 32'h0C};
        vecs[7] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0C};
        vecs[8] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
        vecs[9] = '{1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h14};

        resetDut();
        mem_lat = 1;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].redir, vecs[i].tgt, vecs[i].rdy, vecs[i].req_rdy);
            checkOutput($sformatf("tbl%0d_req_valid", i), 32'(s_req_valid),
                        32'(vecs[i].exp_req_valid));
            if (vecs[i].exp_req_valid) begin
                checkOutput($sformatf("tbl%0d_req_addr", i), s_req_addr, vecs[i].exp_req_addr);
            end
            checkOutput($sformatf("tbl%0d_inst_valid", i), 32'(s_inst_valid),
                        32'(vecs[i].exp_inst_valid));
            if (vecs[i].exp_inst_valid) begin
                checkOutput($sformatf("tbl%0d_inst_pc", i), s_inst_pc, vecs[i].exp_inst_pc);
            end
        end

        // Drain, then redirect with two requests in flight on a 2-cycle memory.
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        mem_lat = 2;
        applyStimulus(1'b1, 32'h10, 1'b1, 1'b1);
        checkOutput("rd_t0_req_valid", 32'(s_req_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("rd_t1_req_valid", 32'(s_req_valid), 32'd1);
        checkOutput("rd_t1_req_addr", s_req_addr, 32'h10);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("rd_t2_req_addr", s_req_addr, 32'h14);
        checkOutput("rd_t2_inflight", 32'(pend_addr.size()), 32'd2);
        applyStimulus(1'b1, 32'h100, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("rd_t4_req_valid", 32'(s_req_valid), 32'd1);
        checkOutput("rd_t4_req_addr", s_req_addr, 32'h100);
        checkOutput("rd_t4_inst_valid", 32'(s_inst_valid), 32'd0);
        found = 1'b0;
        for (int k = 0; k < 8 && !found; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
            if (s_inst_valid) begin
                found = 1'b1;
                checkOutput("rd_first_pc", s_inst_pc, 32'h100);
            end
        end
        checkOutput("rd_first_seen", 32'(found), 32'd1);

        // Redirect coinciding with the only outstanding response.
        mem_lat = 1;
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("sc_inflight", 32'(pend_addr.size()), 32'd1);
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("sc_req_addr", s_req_addr, 32'h200);
        checkOutput("sc_t1_inst_valid", 32'(s_inst_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("sc_t2_inst_valid", 32'(s_inst_valid), 32'd0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("sc_t3_inst_valid", 32'(s_inst_valid), 32'd1);
        checkOutput("sc_t3_inst_pc", s_inst_pc, 32'h200);

        // Fetch PC wraps from the top of the address space.
        applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap_req_top", s_req_addr, 32'hFFFF_FFFC);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("wrap_req_zero", s_req_addr, 32'h0);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);

`ifdef FETCH_MISALIGN_CHK_EN
        applyStimulus(1'b1, 32'h102, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("mis_req_valid", 32'(s_req_valid), 32'd0);
        checkOutput("mis_inst_valid", 32'(s_inst_valid), 32'd1);
        checkOutput("mis_inst_pc", s_inst_pc, 32'h102);
        checkOutput("mis_inst", s_inst, NopInst);
        checkOutput("mis_flag", 32'(s_misaligned), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkOutput("mis_hold_req_valid", 32'(s_req_valid), 32'd0);
        applyStimulus(1'b1, 32'h200, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("mis_resume_req_valid", 32'(s_req_valid), 32'd1);
        checkOutput("mis_resume_req_addr", s_req_addr, 32'h200);
        checkOutput("mis_resume_inst_valid", 32'(s_inst_valid), 32'd0);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
`endif

        // Reset asserted mid-stream clears state immediately.
        repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        resetDut();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("post_rst_req_valid", 32'(s_req_valid), 32'd1);
        checkOutput("post_rst_req_addr", s_req_addr, 32'h0);

        // Randomized traffic against the stream model.
        for (int n = 0; n < 1500; n++) begin
            mem_lat = $urandom_range(1, 3);
            tgt = $urandom();
            tgt[1:0] = 2'b00;
            applyStimulus(($urandom_range(0, 15) == 0), tgt,
                          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
        end

        mem_lat = 1;
        d0 = deliveries;
        repeat (30) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkOutput("liveness", 32'((deliveries - d0) >= 20), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
        $finish;
    end

endmodule
